// File: rtl/demux_1to2_stage_pkg.sv
// Shared types and defaults for the 1-to-2 demux stage.
// Lane select encoding and default sizing live here.
package demux_1to2_stage_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 2;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

endpackage

// File: rtl/demux_1to2_stage_lane_fifo.sv
// Per-lane FIFO: registered head, count-based full/empty.
// Storage resets to zero so the head never shows X.
module lane_fifo
    import demux_1to2_stage_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Push and pop together leave the occupancy unchanged.
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/demux_1to2_stage.sv
// Registered 1-to-2 demux: one producer steered into two
// independently buffered consumer lanes.
module demux_1to2_stage
    import demux_1to2_stage_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] lane0_count,
    output logic [CNT_W-1:0] lane1_count
);

    logic full0, full1;
    logic empty0, empty1;
    logic push0, push1;
    logic pop0, pop1;
    logic accept;

    // Ready depends only on the select and registered full flags.
    always_comb begin
        in_ready = 1'b1;
        unique case (lane_e'(in_sel))
            LANE0:   in_ready = !full0;
            LANE1:   in_ready = !full1;
            default: in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign push0  = accept && (lane_e'(in_sel) == LANE0);
    assign push1  = accept && (lane_e'(in_sel) == LANE1);

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign pop0       = out0_valid && out0_ready;
    assign pop1       = out1_valid && out1_ready;

    lane_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_lane0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push0),
        .push_data(in_data),
        .pop      (pop0),
        .head_data(out0_data),
        .count    (lane0_count),
        .full     (full0),
        .empty    (empty0)
    );

    lane_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_lane1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push1),
        .push_data(in_data),
        .pop      (pop1),
        .head_data(out1_data),
        .count    (lane1_count),
        .full     (full1),
        .empty    (empty1)
    );

endmodule

// File: tb/tb_demux_1to2_stage.sv
// Bench for demux_1to2_stage: vector table, corner sequences,
// and randomized traffic against a queue-based lane model.
module tb_demux_1to2_stage;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [CNT_W-1:0] lane0_count;
    logic [CNT_W-1:0] lane1_count;

    int n_total;
    int n_pass;

    demux_1to2_stage #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .lane0_count(lane0_count),
        .lane1_count(lane1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        sel;
        logic [31:0] d;
        logic        r0;
        logic        r1;
        logic        e_rdy;
        logic        e_v0;
        logic [31:0] e_d0;
        logic [1:0]  e_c0;
        logic        e_v1;
        logic [31:0] e_d1;
        logic [1:0]  e_c1;
    } vec_t;

    vec_t vecs [14];

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h",
                      name, act, exp);
    endtask

    task automatic drive(input logic v, input logic sel,
                         input logic [31:0] d, input logic r0,
                         input logic r1);
        in_valid   = v;
        in_sel     = sel;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
    endtask

    function automatic vec_t mk(
        logic v, logic sel, logic [31:0] d, logic r0, logic r1,
        logic e_rdy, logic e_v0, logic [31:0] e_d0, logic [1:0] e_c0,
        logic e_v1, logic [31:0] e_d1, logic [1:0] e_c1);
        vec_t t;
        t.v = v; t.sel = sel; t.d = d; t.r0 = r0; t.r1 = r1;
        t.e_rdy = e_rdy;
        t.e_v0 = e_v0; t.e_d0 = e_d0; t.e_c0 = e_c0;
        t.e_v1 = e_v1; t.e_d1 = e_d1; t.e_c1 = e_c1;
        return t;
    endfunction

    initial begin
        logic [31:0] lane_got0 [$];
        logic [31:0] lane_got1 [$];
        logic        held;
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Backpressure, isolation, full push/pop, drain, steering.
        vecs[0]  = mk(1,0,32'h1,0,0, 1, 1,32'h1,1, 0,32'h0,0);
        vecs[1]  = mk(1,0,32'h2,0,0, 1, 1,32'h1,2, 0,32'h0,0);
        vecs[2]  = mk(1,0,32'h3,0,0, 0, 1,32'h1,2, 0,32'h0,0);
        vecs[3]  = mk(1,0,32'h3,1,0, 0, 1,32'h2,1, 0,32'h0,0);
        vecs[4]  = mk(1,0,32'h3,0,0, 1, 1,32'h2,2, 0,32'h0,0);
        vecs[5]  = mk(1,1,32'hA5A5A5A5,0,0, 1, 1,32'h2,2,
                      1,32'hA5A5A5A5,1);
        vecs[6]  = mk(1,1,32'hB,0,0, 1, 1,32'h2,2,
                      1,32'hA5A5A5A5,2);
        vecs[7]  = mk(1,1,32'hC,0,1, 0, 1,32'h2,2, 1,32'hB,1);
        vecs[8]  = mk(1,1,32'hC,0,0, 1, 1,32'h2,2, 1,32'hB,2);
        vecs[9]  = mk(0,0,32'h0,1,1, 0, 1,32'h3,1, 1,32'hC,1);
        vecs[10] = mk(0,0,32'h0,1,1, 1, 0,32'h0,0, 0,32'h0,0);
        vecs[11] = mk(1,0,32'hDEADBEEF,1,1, 1, 1,32'hDEADBEEF,1,
                      0,32'h0,0);
        vecs[12] = mk(1,1,32'h12345678,1,1, 1, 0,32'h0,0,
                      1,32'h12345678,1);
        vecs[13] = mk(0,0,32'h0,1,1, 1, 0,32'h0,0, 0,32'h0,0);

        // Reset state.
        tick();
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_v0", {31'h0, out0_valid}, 32'h0);
        chk("rst_v1", {31'h0, out1_valid}, 32'h0);
        chk("rst_d0", out0_data, 32'h0);
        chk("rst_d1", out1_data, 32'h0);
        chk("rst_c0", {30'h0, lane0_count}, 32'h0);
        chk("rst_c1", {30'h0, lane1_count}, 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].sel, vecs[i].d,
                  vecs[i].r0, vecs[i].r1);
            #1;
            chk($sformatf("vec%0d_rdy", i),
                {31'h0, in_ready}, {31'h0, vecs[i].e_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_v0", i),
                {31'h0, out0_valid}, {31'h0, vecs[i].e_v0});
            chk($sformatf("vec%0d_c0", i),
                {30'h0, lane0_count}, {30'h0, vecs[i].e_c0});
            chk($sformatf("vec%0d_v1", i),
                {31'h0, out1_valid}, {31'h0, vecs[i].e_v1});
            chk($sformatf("vec%0d_c1", i),
                {30'h0, lane1_count}, {30'h0, vecs[i].e_c1});
            if (vecs[i].e_v0)
                chk($sformatf("vec%0d_d0", i), out0_data, vecs[i].e_d0);
            if (vecs[i].e_v1)
                chk($sformatf("vec%0d_d1", i), out1_data, vecs[i].e_d1);
        end

        // Wrap and throughput: 10 back-to-back words, alternating lanes.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i[0], i, 1'b1, 1'b1);
            #1;
            chk($sformatf("wrap%0d_rdy", i), {31'h0, in_ready}, 32'h1);
            @(posedge clk);
            #1;
            if (out0_valid) lane_got0.push_back(out0_data);
            if (out1_valid) lane_got1.push_back(out1_data);
            if (i[0]) chk($sformatf("wrap%0d_v1", i),
                          {31'h0, out1_valid}, 32'h1);
            else      chk($sformatf("wrap%0d_v0", i),
                          {31'h0, out0_valid}, 32'h1);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        chk("wrap_n0", lane_got0.size(), 32'd5);
        chk("wrap_n1", lane_got1.size(), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < lane_got0.size())
                chk($sformatf("wrap_l0_%0d", k), lane_got0[k], 2 * k);
            if (k < lane_got1.size())
                chk($sformatf("wrap_l1_%0d", k), lane_got1[k], 2 * k + 1);
        end
        chk("wrap_idle_c0", {30'h0, lane0_count}, 32'h0);
        chk("wrap_idle_c1", {30'h0, lane1_count}, 32'h0);

        // Asynchronous reset with lane0 holding two words.
        drive(1'b1, 1'b0, 32'h11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h22, 1'b0, 1'b0);
        tick();
        chk("pre_rst_c0", {30'h0, lane0_count}, 32'h2);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_c0", {30'h0, lane0_count}, 32'h0);
        chk("arst_v0", {31'h0, out0_valid}, 32'h0);
        chk("arst_v1", {31'h0, out1_valid}, 32'h0);
        chk("arst_rdy", {31'h0, in_ready}, 32'h1);
        chk("arst_d0", out0_data, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_d0", out0_data, 32'h0);
        chk("post_rst_c0", {30'h0, lane0_count}, 32'h0);

        // Randomized traffic against a queue model of each lane.
        do_reset();
        held = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic        v, sel, r0, r1, rdy_m;
            logic [31:0] d;
            if (held) begin
                v = 1'b1; sel = in_sel; d = in_data;
            end else begin
                v   = ($urandom_range(0, 3) != 0);
                sel = 1'($urandom_range(0, 1));
                d   = $urandom;
            end
            r0 = ($urandom_range(0, 2) != 0);
            r1 = ($urandom_range(0, 3) == 0);
            drive(v, sel, d, r0, r1);
            #1;
            rdy_m = sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
            chk("rnd_rdy", {31'h0, in_ready}, {31'h0, rdy_m});
            @(posedge clk);
            #1;
            if (r0 && q0.size() > 0) void'(q0.pop_front());
            if (r1 && q1.size() > 0) void'(q1.pop_front());
            if (v && rdy_m) begin
                if (sel) q1.push_back(d);
                else     q0.push_back(d);
            end
            held = v && !rdy_m;
            chk("rnd_c0", {30'h0, lane0_count}, q0.size());
            chk("rnd_c1", {30'h0, lane1_count}, q1.size());
            chk("rnd_v0", {31'h0, out0_valid}, {31'h0, q0.size() > 0});
            chk("rnd_v1", {31'h0, out1_valid}, {31'h0, q1.size() > 0});
            if (q0.size() > 0) chk("rnd_d0", out0_data, q0[0]);
            if (q1.size() > 0) chk("rnd_d1", out1_data, q1[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
